uba_intr_ack: RTL and testbench

Interrupt-acknowledge responder for the UBA, the acknowledge side of the UBA interrupt request path.
- When the CPU issues a "who are you" (WRU) read for a PI level, the block arbitrates among pending device requests mapped to that level.
- It hands an acknowledge to the winning device, captures the device's vector, and returns it as the WRU read data.
- It sits between the UBA bus interface and the five device interrupt request/acknowledge lines.

---
 rtl/uba_intr_pkg.sv | 11 +
 rtl/uba_intr_ack_if.sv | 24 ++
 rtl/uba_intr_arb.sv | 40 ++++
 rtl/uba_intr_ack.sv | 87 ++++++++
 tb/tb_uba_intr_ack.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uba_intr_pkg.sv
// uba_intr_pkg: shared states, BR indices and widths for the UBA interrupt-acknowledge responder
package uba_intr_pkg;
  typedef enum logic [1:0] {IDLE, ARB, ACK, RESP} state_e;
  localparam int BR7 = 7;
  localparam int BR6 = 6;
  localparam int BR5 = 5;
  localparam int BR4 = 4;
  localparam int N_DEV = 5;
  localparam int VECT_W = 18;
  localparam int DATA_W = 36;
endpackage

// File: rtl/uba_intr_ack_if.sv
// uba_intr_ack_if: WRU bus side and device interrupt lines of the interrupt-acknowledge responder
interface uba_intr_ack_if;
  import uba_intr_pkg::*;
  logic wruREQ;
  logic [2:0] wruPI;
  logic [2:0] statPIH;
  logic [2:0] statPIL;
  logic [1:N_DEV][BR7:BR4] devINTR;
  logic [1:N_DEV] devACK;
  logic [BR7:BR4] devACKBR;
  logic devVECTV;
  logic [0:VECT_W-1] devVECT;
  logic wruACK;
  logic [0:DATA_W-1] wruDATA;
  logic wruTMO;
  modport slave (
    input wruREQ, wruPI, statPIH, statPIL, devINTR, devVECTV, devVECT,
    output devACK, devACKBR, wruACK, wruDATA, wruTMO
  );
  modport master (
    output wruREQ, wruPI, statPIH, statPIL, devINTR, devVECTV, devVECT,
    input devACK, devACKBR, wruACK, wruDATA, wruTMO
  );
endinterface

// File: rtl/uba_intr_arb.sv
// uba_intr_arb: picks the group, BR level and device that answer a WRU for one PI level
module uba_intr_arb
  import uba_intr_pkg::*;
(
  input  logic [2:0] i_level,
  input  logic [2:0] i_pih,
  input  logic [2:0] i_pil,
  input  logic [1:N_DEV][BR7:BR4] i_intr,
  output logic o_valid,
  output logic [1:N_DEV] o_dev,
  output logic [BR7:BR4] o_br
);
  logic [BR7:BR4][1:N_DEV] w_col;
  logic [1:N_DEV] w_req;
  logic w_hi;
  logic w_lo;
  logic w_found;
  for (genvar b = BR4; b <= BR7; b++) begin : g_br
    for (genvar d = 1; d <= N_DEV; d++) begin : g_dev
      assign w_col[b][d] = i_intr[d][b];
    end
  end
  // PI 0 means the group is disabled, so it never matches
  assign w_hi = (i_level != 3'd0) && (i_pih == i_level) && |{w_col[BR7], w_col[BR6]};
  assign w_lo = (i_level != 3'd0) && (i_pil == i_level) && |{w_col[BR5], w_col[BR4]};
  assign o_valid = w_hi || w_lo;
  assign o_br = w_hi ? (|w_col[BR7] ? 4'b1000 : 4'b0100)
              : w_lo ? (|w_col[BR5] ? 4'b0010 : 4'b0001) : 4'b0000;
  assign w_req = ({N_DEV{o_br[BR7]}} & w_col[BR7]) | ({N_DEV{o_br[BR6]}} & w_col[BR6])
               | ({N_DEV{o_br[BR5]}} & w_col[BR5]) | ({N_DEV{o_br[BR4]}} & w_col[BR4]);
  // lowest-numbered requesting device wins within the chosen BR level
  always_comb begin
    o_dev = '0;
    w_found = 1'b0;
    for (int d = 1; d <= N_DEV; d++) begin
      o_dev[d] = w_req[d] && !w_found;
      w_found = w_found || w_req[d];
    end
  end
endmodule

// File: rtl/uba_intr_ack.sv
// uba_intr_ack: WRU interrupt-acknowledge responder; optional ACK timeout under UBA_WRU_TIMEOUT_EN
module uba_intr_ack
  import uba_intr_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNTW = 7
) (
  input logic clk,
  input logic rst,
  uba_intr_ack_if.slave bus
);
  state_e r_state;
  state_e w_next;
  logic [2:0] r_pi;
  logic [1:N_DEV] r_dev;
  logic [1:N_DEV] w_dev;
  logic [BR7:BR4] r_br;
  logic [BR7:BR4] w_br;
  logic w_win;
  logic w_expire;
  logic [0:VECT_W-1] w_vect;
  logic [0:DATA_W-1] r_data;
  if (2 ** CNTW <= TIMEOUT) begin : g_bad_cntw
    $error("uba_intr_ack: CNTW too narrow for TIMEOUT");
  end
  uba_intr_arb u_arb (
    .i_level(r_pi),
    .i_pih(bus.statPIH),
    .i_pil(bus.statPIL),
    .i_intr(bus.devINTR),
    .o_valid(w_win),
    .o_dev(w_dev),
    .o_br(w_br)
  );
`ifdef UBA_WRU_TIMEOUT_EN
  logic [CNTW-1:0] r_cnt;
  logic r_tmo;
  assign w_expire = (r_state == ACK) && !bus.devVECTV && (r_cnt == CNTW'(TIMEOUT - 1));
  // counter idles at zero outside ACK so every ACK starts fresh; timeout flag is sticky
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= (r_state == ACK) ? r_cnt + 1'b1 : '0;
      r_tmo <= r_tmo || w_expire;
    end
  assign bus.wruTMO = r_tmo;
`else
  assign w_expire = 1'b0;
  assign bus.wruTMO = 1'b0;
`endif
  // next-state logic; WRU strobes outside IDLE are dropped, not queued
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = bus.wruREQ ? ARB : IDLE;
      ARB: w_next = w_win ? ACK : RESP;
      ACK: w_next = (bus.devVECTV || w_expire) ? RESP : ACK;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  assign w_vect = (r_state == ACK && bus.devVECTV) ? bus.devVECT : '0;
  // latch the requested level, the arbitration winner, and the response word on RESP entry
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pi <= '0;
      r_dev <= '0;
      r_br <= '0;
      r_data <= '0;
    end else begin
      if (r_state == IDLE && bus.wruREQ) r_pi <= bus.wruPI;
      if (r_state == ARB) begin
        r_dev <= w_dev;
        r_br <= w_br;
      end
      if (w_next == RESP) r_data <= {{(DATA_W - VECT_W){1'b0}}, w_vect};
    end
  assign bus.devACK = (r_state == ACK) ? r_dev : '0;
  assign bus.devACKBR = (r_state == ACK) ? r_br : '0;
  assign bus.wruACK = (r_state == RESP);
  assign bus.wruDATA = r_data;
endmodule

// File: tb/tb_uba_intr_ack.sv
// tb_uba_intr_ack: directed and randomized checks of uba_intr_ack against a behavioural model
module tb_uba_intr_ack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [35:0] last_data = '0;
  uba_intr_ack_if bus();
  uba_intr_ack dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // winner search straight from the rules: high group first, BR descending, device ascending
  function automatic void model(input int pi, input int pih, input int pil,
                                input logic [1:5][7:4] intr, output int dev, output int br);
    dev = 0;
    br = 0;
    for (int g = 0; g < 2; g++) begin
      if ((g == 0 ? pih : pil) != pi || dev != 0) continue;
      for (int b = 7 - 2 * g; b >= 6 - 2 * g; b--)
        for (int d = 1; d <= 5; d++)
          if (dev == 0 && intr[d][b]) begin
            dev = d;
            br = b;
          end
    end
  endfunction

  function automatic logic [35:0] dev_oh(input int d);
    return d == 0 ? 36'd0 : 36'd1 << (5 - d);
  endfunction

  function automatic logic [35:0] br_oh(input int b);
    return b == 0 ? 36'd0 : 36'd1 << (b - 4);
  endfunction

  // issue a WRU and advance to cycle 2 (ACK, or RESP when nobody wins)
  task automatic issue(input string tag, input int pi);
    bus.wruPI = 3'(pi);
    bus.wruREQ = 1'b1;
    step();
    bus.wruREQ = 1'b0;
    check({tag, " arb devACK"}, 36'(bus.devACK), 36'd0);
    check({tag, " arb wruACK"}, 36'(bus.wruACK), 36'd0);
    step();
  endtask

  task automatic txn(input string tag, input int pih, input int pil, input int pi,
                     input logic [1:5][7:4] intr, input int wait_n, input logic [17:0] vect,
                     input bit churn);
    int dev, br;
    bus.statPIH = 3'(pih);
    bus.statPIL = 3'(pil);
    bus.devINTR = intr;
    model(pi, pih, pil, intr, dev, br);
    issue(tag, pi);
    if (dev == 0) begin
      check({tag, " nowin wruACK"}, 36'(bus.wruACK), 36'd1);
      check({tag, " nowin devACK"}, 36'(bus.devACK), 36'd0);
      check({tag, " nowin data"}, 36'(bus.wruDATA), 36'd0);
      last_data = '0;
    end else begin
      check({tag, " devACK"}, 36'(bus.devACK), dev_oh(dev));
      check({tag, " devACKBR"}, 36'(bus.devACKBR), br_oh(br));
      for (int i = 0; i < wait_n; i++) begin
        if (churn) begin
          bus.devINTR = 20'($urandom);
          bus.wruREQ = 1'($urandom);
        end
        step();
        check({tag, " hold devACK"}, 36'(bus.devACK), dev_oh(dev));
        check({tag, " hold wruACK"}, 36'(bus.wruACK), 36'd0);
      end
      bus.wruREQ = 1'b0;
      bus.devVECTV = 1'b1;
      bus.devVECT = vect;
      step();
      bus.devVECTV = 1'b0;
      check({tag, " resp wruACK"}, 36'(bus.wruACK), 36'd1);
      check({tag, " resp data"}, 36'(bus.wruDATA), 36'(vect));
      check({tag, " resp devACK"}, 36'(bus.devACK), 36'd0);
      last_data = 36'(vect);
    end
    step();
    check({tag, " post wruACK"}, 36'(bus.wruACK), 36'd0);
    check({tag, " post data"}, 36'(bus.wruDATA), last_data);
    step();
    check({tag, " no requeue"}, 36'(bus.devACK), 36'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:5][7:4] x;
    logic [17:0] v;
    int pi, pih, pil, dev, br, seen;
    bus.wruREQ = 1'b0;
    bus.wruPI = '0;
    bus.statPIH = '0;
    bus.statPIL = '0;
    bus.devINTR = '0;
    bus.devVECTV = 1'b0;
    bus.devVECT = '0;
    #1 rst = 1'b0;
    step();
    step();
    check("reset devACK", 36'(bus.devACK), 36'd0);
    check("reset devACKBR", 36'(bus.devACKBR), 36'd0);
    check("reset wruACK", 36'(bus.wruACK), 36'd0);
    check("reset wruDATA", 36'(bus.wruDATA), 36'd0);
    check("reset wruTMO", 36'(bus.wruTMO), 36'd0);
    rst = 1'b1;
    step();
    x = '0; x[3][6] = 1'b1;
    txn("tp1", 4, 0, 4, x, 2, 18'o000300, 1'b0);
    x = '0; x[2][5] = 1'b1; x[4][7] = 1'b1;
    txn("tp2", 5, 5, 5, x, 1, 18'o123456, 1'b0);
    x = '0; x[1][4] = 1'b1; x[2][5] = 1'b1;
    txn("tp3a", 1, 6, 6, x, 0, 18'o777777, 1'b0);
    x[2][5] = 1'b0;
    txn("tp3b", 1, 6, 6, x, 3, 18'o000004, 1'b0);
    x = '1;
    txn("tp4", 4, 6, 3, x, 0, 18'o1, 1'b0);
    bus.devVECTV = 1'b1;
    bus.devVECT = 18'o525252;
    step();
    bus.devVECTV = 1'b0;
    check("idle vectv wruACK", 36'(bus.wruACK), 36'd0);
    check("idle vectv data", 36'(bus.wruDATA), last_data);
    x = '0; x[5][7] = 1'b1;
    txn("pre-rst", 2, 0, 2, x, 0, 18'o4321, 1'b0);
    bus.statPIH = 3'd2;
    issue("rst", 2);
    check("rst pre devACK", 36'(bus.devACK), dev_oh(5));
    #2 rst = 1'b0;
    #1;
    check("rst async devACK", 36'(bus.devACK), 36'd0);
    check("rst async devACKBR", 36'(bus.devACKBR), 36'd0);
    check("rst async data", 36'(bus.wruDATA), 36'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    last_data = '0;
    step();
    check("rst idle devACK", 36'(bus.devACK), 36'd0);
    check("rst idle wruACK", 36'(bus.wruACK), 36'd0);
    txn("after-rst", 2, 0, 2, x, 1, 18'o7070, 1'b0);
`ifdef UBA_WRU_TIMEOUT_EN
    x = '0; x[1][5] = 1'b1;
    txn("vect-at-expiry", 0, 3, 3, x, 63, 18'o112233, 1'b0);
    check("vect-at-expiry tmo", 36'(bus.wruTMO), 36'd0);
    bus.statPIL = 3'd3;
    issue("tmo", 3);
    seen = 0;
    for (int i = 0; i < 63; i++) begin
      bus.wruREQ = (i == 10);
      step();
      seen += int'(bus.wruACK);
    end
    bus.wruREQ = 1'b0;
    check("tmo early wruACK", 36'(seen), 36'd0);
    step();
    check("tmo wruACK", 36'(bus.wruACK), 36'd1);
    check("tmo data", 36'(bus.wruDATA), 36'd0);
    check("tmo flag", 36'(bus.wruTMO), 36'd1);
    last_data = '0;
    step();
    step();
    check("tmo second wru ignored", 36'(bus.devACK), 36'd0);
    check("tmo sticky", 36'(bus.wruTMO), 36'd1);
`else
    x = '0; x[1][5] = 1'b1;
    bus.statPIH = 3'd0;
    bus.statPIL = 3'd3;
    bus.devINTR = x;
    issue("notmo", 3);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      seen += int'(bus.wruACK);
    end
    check("notmo no wruACK", 36'(seen), 36'd0);
    check("notmo devACK", 36'(bus.devACK), dev_oh(1));
    check("notmo tmo", 36'(bus.wruTMO), 36'd0);
    bus.devVECTV = 1'b1;
    bus.devVECT = 18'o246;
    step();
    bus.devVECTV = 1'b0;
    check("notmo resp wruACK", 36'(bus.wruACK), 36'd1);
    check("notmo resp data", 36'(bus.wruDATA), 36'o246);
    step();
`endif
    for (int t = 0; t < 40; t++) begin
      pi = $urandom_range(1, 7);
      pih = ($urandom % 2) ? pi : $urandom_range(0, 7);
      pil = ($urandom % 2) ? pi : $urandom_range(0, 7);
      x = 20'($urandom & $urandom);
      v = 18'($urandom);
      txn($sformatf("rnd%0d", t), pih, pil, pi, x, $urandom_range(0, 5), v, 1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
